// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: word width, boot
// address default and the fetch FSM state encoding.
package fetch_unit_pkg;

    localparam int unsigned WORD_WIDTH = 32;
    localparam logic [WORD_WIDTH-1:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory req/gnt/rvalid port, decode
// valid/ready port and the execute redirect. FETCH_MISALIGN_CHECK_EN adds the misalign flag.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic                  instr_req_o;
    logic [WORD_WIDTH-1:0] instr_addr_o;
    logic                  instr_gnt_i;
    logic                  instr_rvalid_i;
    logic [WORD_WIDTH-1:0] instr_rdata_i;
    logic                  instr_valid_o;
    logic [WORD_WIDTH-1:0] instr_o;
    logic [WORD_WIDTH-1:0] pc_o;
    logic                  instr_ready_i;
    logic                  branch_i;
    logic [WORD_WIDTH-1:0] branch_target_i;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic                  fetch_misaligned_o;
`endif

    modport master (
`ifdef FETCH_MISALIGN_CHECK_EN
        output fetch_misaligned_o,
`endif
        output instr_req_o, instr_addr_o, instr_valid_o, instr_o, pc_o,
        input  instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_ready_i,
               branch_i, branch_target_i
    );

    modport slave (
`ifdef FETCH_MISALIGN_CHECK_EN
        input  fetch_misaligned_o,
`endif
        input  instr_req_o, instr_addr_o, instr_valid_o, instr_o, pc_o,
        output instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_ready_i,
               branch_i, branch_target_i
    );

endinterface

// File: rtl/fetch_unit_fetch_fifo.sv
// Synchronous FIFO of {instr, pc} entries with flush; DEPTH must be a power of two.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the top masks the head while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: one outstanding memory fetch, buffered {instr, pc}
// FIFO toward decode, branch redirect with flush. Optional: FETCH_MISALIGN_CHECK_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned           FIFO_DEPTH = 2,
    parameter logic [WORD_WIDTH-1:0] BOOT_ADDR  = BOOT_ADDR_DEFAULT
) (
    input  logic         clk_i,
    input  logic         rst_i,
    fetch_unit_if.master bus
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e            state_q, state_d;
    logic [WORD_WIDTH-1:0]   pc_q, pc_d;
    logic [WORD_WIDTH-1:0]   addr_q, addr_d;
    logic                    discard_q, discard_d;
    logic [WORD_WIDTH-1:0]   target, pc_eff;
    logic                    push, pop, empty, halt, space;
    logic [CNT_W-1:0]        count, count_nxt;
    logic [2*WORD_WIDTH-1:0] head;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned_q, misaligned_d;

    assign target = bus.branch_target_i;

    always_comb begin
        misaligned_d = misaligned_q;
        if (bus.branch_i) misaligned_d = |bus.branch_target_i[1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) misaligned_q <= 1'b0;
        else       misaligned_q <= misaligned_d;
    end

    assign halt                   = misaligned_d;
    assign bus.fetch_misaligned_o = misaligned_q;
`else
    assign target = bus.branch_target_i & ~WORD_WIDTH'(3);
    assign halt   = 1'b0;
`endif

    // pc_q is the address of the next fresh request; addr_q is the one on the bus
    // (and the PC recorded for the outstanding response).
    assign pc_eff    = bus.branch_i ? target : pc_q;
    assign push      = (state_q == WAIT) && bus.instr_rvalid_i && !discard_q && !bus.branch_i;
    assign pop       = !empty && bus.instr_ready_i && !bus.branch_i;
    assign count_nxt = bus.branch_i ? '0 : count + CNT_W'(push) - CNT_W'(pop);
    assign space     = (count_nxt < CNT_W'(FIFO_DEPTH)) && !halt;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        discard_d = discard_q;
        if (bus.branch_i) pc_d = target;
        case (state_q)
            IDLE: begin
                if (space) begin
                    state_d = REQ;
                    addr_d  = pc_eff;
                    pc_d    = pc_eff + WORD_WIDTH'(4);
                end
            end
            REQ: begin
                // A redirect cannot retract a request: it stays up until granted,
                // and its response is marked for dropping.
                if (bus.branch_i)    discard_d = 1'b1;
                if (bus.instr_gnt_i) state_d   = WAIT;
            end
            WAIT: begin
                if (bus.branch_i) discard_d = 1'b1;
                if (bus.instr_rvalid_i) begin
                    discard_d = 1'b0;
                    state_d   = space ? REQ : IDLE;
                    if (space) begin
                        addr_d = pc_eff;
                        pc_d   = pc_eff + WORD_WIDTH'(4);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            pc_q      <= BOOT_ADDR;
            addr_q    <= BOOT_ADDR;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            discard_q <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2 * WORD_WIDTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (bus.branch_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  ({bus.instr_rdata_i, addr_q}),
        .data_o  (head),
        .count_o (count),
        .empty_o (empty)
    );

    assign bus.instr_req_o   = (state_q == REQ);
    assign bus.instr_addr_o  = addr_q;
    assign bus.instr_valid_o = !empty;
    assign bus.instr_o       = empty ? '0 : head[2*WORD_WIDTH-1:WORD_WIDTH];
    assign bus.pc_o          = empty ? '0 : head[WORD_WIDTH-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized memory/decode/branch
// traffic checked against an expected-PC-stream model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] BOOT  = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(
        .FIFO_DEPTH (DEPTH),
        .BOOT_ADDR  (BOOT)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    // Environment knobs
    int gnt_wait_cfg = 0;   // <0: random grant, else grant after N held cycles
    int lat_min = 0, lat_max = 0, ready_pct = 100, branch_pct = 0;
    int arm_mode = 0;       // 1: on req, 2: cycle after grant of arm_addr, 3: now
    logic [31:0] arm_target = '0, arm_addr = '0;
    bit do_rst = 1'b1;

    // Memory and reference model state
    bit pend_v = 0, pend_stale = 0;
    logic [31:0] pend_addr = '0;
    int pend_cnt = 0, hc = 0, cyc = 0, first_req_cyc = -1, first_vld_cyc = -1;
    logic [31:0] exp_pc = BOOT, exp_req = BOOT;
    bit prev_held = 0, prev_branch = 0, prev_rst = 0, prev_gnt = 0;
    logic [31:0] prev_addr = '0, prev_gnt_addr = '0;
    logic [31:0] gnt_log[$];
    logic [31:0] dlv_log[$];

    task automatic tick();
        bit br, rdy, g, rv, fresh;
        logic [31:0] tgt, tgt_eff, rv_addr;
        @(negedge clk);
        cyc++;
        br = 0; rdy = 0; g = 0; rv = 0; tgt = '0; rv_addr = '0;
        if (prev_rst) begin
            check_eq("rst_req",   32'(bus.instr_req_o),   32'd0);
            check_eq("rst_addr",  bus.instr_addr_o,       BOOT);
            check_eq("rst_valid", 32'(bus.instr_valid_o), 32'd0);
            check_eq("rst_instr", bus.instr_o,            32'd0);
            check_eq("rst_pc",    bus.pc_o,               32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
            check_eq("rst_misaligned", 32'(bus.fetch_misaligned_o), 32'd0);
`endif
        end
        if (prev_branch) check_eq("valid_after_branch", 32'(bus.instr_valid_o), 32'd0);
        if (prev_held) begin
            check_eq("req_held",  32'(bus.instr_req_o), 32'd1);
            check_eq("addr_held", bus.instr_addr_o, prev_addr);
        end
        fresh = (bus.instr_req_o === 1'b1) && !prev_held;
        if (fresh) begin
            check_eq("req_addr", bus.instr_addr_o, exp_req);
            check_eq("one_outstanding", 32'(pend_v && !pend_stale), 32'd0);
            exp_req = bus.instr_addr_o + 32'd4;
            if (first_req_cyc < 0) first_req_cyc = cyc;
            hc = 0;
        end else if (bus.instr_req_o === 1'b1) begin
            hc++;
        end
        if (bus.instr_valid_o === 1'b1 && first_vld_cyc < 0) first_vld_cyc = cyc;

        // Redirect decision
        case (arm_mode)
            1: br = (bus.instr_req_o === 1'b1);
            2: br = prev_gnt && (prev_gnt_addr == arm_addr);
            3: br = 1'b1;
            default: br = 1'b0;
        endcase
        if (br) begin
            tgt = arm_target;
            arm_mode = 0;
        end else if (branch_pct > 0 && $urandom_range(99, 0) < branch_pct) begin
            br  = 1'b1;
            tgt = $urandom();
`ifdef FETCH_MISALIGN_CHECK_EN
            tgt[1:0] = 2'b00;
`endif
        end
        if (do_rst) br = 1'b0;
        rdy = ($urandom_range(99, 0) < ready_pct);

        // Memory response and grant
        if (!do_rst && pend_v) begin
            if (pend_cnt == 0) begin
                rv = 1'b1;
                rv_addr = pend_addr;
                pend_v = 1'b0;
                pend_stale = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        if (!do_rst && bus.instr_req_o === 1'b1) begin
            g = (gnt_wait_cfg < 0) ? ($urandom_range(1, 0) == 1) : (hc >= gnt_wait_cfg);
            if (g) begin
                pend_v = 1'b1;
                pend_stale = 1'b0;
                pend_addr = bus.instr_addr_o;
                pend_cnt = $urandom_range(lat_max, lat_min);
                gnt_log.push_back(bus.instr_addr_o);
            end
        end

        // Decode consumption against the expected PC stream
        if (!do_rst && !br && rdy && bus.instr_valid_o === 1'b1) begin
            check_eq("pc",    bus.pc_o,    exp_pc);
            check_eq("instr", bus.instr_o, mem_word(exp_pc));
            dlv_log.push_back(bus.pc_o);
            exp_pc = exp_pc + 32'd4;
        end
        if (br) begin
            tgt_eff = tgt & ~32'd3;
`ifdef FETCH_MISALIGN_CHECK_EN
            tgt_eff = tgt;
`endif
            exp_pc  = tgt_eff;
            exp_req = tgt_eff;
        end
        if (do_rst) begin
            exp_pc  = BOOT;
            exp_req = BOOT;
            if (pend_v) begin
                pend_cnt = 0;
                pend_stale = 1'b1;
            end
        end

        prev_held     = (bus.instr_req_o === 1'b1) && !g && !do_rst;
        prev_addr     = bus.instr_addr_o;
        prev_branch   = br;
        prev_rst      = do_rst;
        prev_gnt      = g;
        prev_gnt_addr = bus.instr_addr_o;

        bus.instr_gnt_i     = g;
        bus.instr_rvalid_i  = rv;
        bus.instr_rdata_i   = rv ? mem_word(rv_addr) : $urandom();
        bus.instr_ready_i   = rdy;
        bus.branch_i        = br;
        bus.branch_target_i = tgt;
        rst                 = do_rst;
        do_rst              = 1'b0;
    endtask

    task automatic do_reset();
        do_rst = 1'b1;
        tick();
        gnt_log.delete();
        dlv_log.delete();
        first_req_cyc = -1;
        first_vld_cyc = -1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int n0;
        bus.instr_gnt_i = 1'b0;
        bus.instr_rvalid_i = 1'b0;
        bus.instr_rdata_i = '0;
        bus.instr_ready_i = 1'b0;
        bus.branch_i = 1'b0;
        bus.branch_target_i = '0;

        // Streaming with single-cycle memory
        gnt_wait_cfg = 0; lat_min = 0; lat_max = 0; ready_pct = 100;
        do_reset();
        run(12);
        check_eq("t1_gnt0", qat(gnt_log, 0), 32'h0);
        check_eq("t1_gnt1", qat(gnt_log, 1), 32'h4);
        check_eq("t1_gnt2", qat(gnt_log, 2), 32'h8);
        check_eq("t1_dlv0", qat(dlv_log, 0), 32'h0);
        check_eq("t1_dlv1", qat(dlv_log, 1), 32'h4);
        check_eq("t1_dlv2", qat(dlv_log, 2), 32'h8);
        check_eq("t1_latency", 32'(first_vld_cyc - first_req_cyc), 32'd2);

        // Decode stalled: fetch stops once the FIFO is reserved full
        ready_pct = 0;
        do_reset();
        run(20);
        check_eq("t2_gnt_count", 32'(gnt_log.size()), 32'd2);
        check_eq("t2_req_idle", 32'(bus.instr_req_o), 32'd0);
        ready_pct = 100;
        run(10);
        check_eq("t2_resume_addr", qat(gnt_log, 2), 32'h8);
        check_eq("t2_dlv0", qat(dlv_log, 0), 32'h0);

        // Redirect while waiting for the response to address 4
        lat_min = 3; lat_max = 3;
        do_reset();
        arm_mode = 2; arm_addr = 32'h4; arm_target = 32'h100;
        run(40);
        check_eq("t3_gnt1", qat(gnt_log, 1), 32'h4);
        check_eq("t3_gnt2", qat(gnt_log, 2), 32'h100);
        check_eq("t3_dlv0", qat(dlv_log, 0), 32'h0);
        check_eq("t3_dlv1", qat(dlv_log, 1), 32'h100);

        // Redirect during a request whose grant is delayed
        lat_min = 0; lat_max = 0; gnt_wait_cfg = 3;
        do_reset();
        arm_mode = 1; arm_target = 32'h200;
        run(30);
        check_eq("t4_gnt0", qat(gnt_log, 0), 32'h0);
        check_eq("t4_gnt1", qat(gnt_log, 1), 32'h200);
        check_eq("t4_dlv0", qat(dlv_log, 0), 32'h200);

        // Fetch PC wrap
        gnt_wait_cfg = 0;
        do_reset();
        arm_mode = 3; arm_target = 32'hFFFF_FFFC;
        run(12);
        check_eq("t5_gnt0", qat(gnt_log, 0), 32'hFFFF_FFFC);
        check_eq("t5_gnt1", qat(gnt_log, 1), 32'h0);
        check_eq("t5_dlv0", qat(dlv_log, 0), 32'hFFFF_FFFC);
        check_eq("t5_dlv1", qat(dlv_log, 1), 32'h0);

`ifdef FETCH_MISALIGN_CHECK_EN
        do_reset();
        run(6);
        arm_mode = 3; arm_target = 32'h102;
        run(2);
        check_eq("t6_flag_set", 32'(bus.fetch_misaligned_o), 32'd1);
        n0 = gnt_log.size();
        run(8);
        check_eq("t6_no_fetch", 32'(gnt_log.size()), 32'(n0));
        check_eq("t6_req_low", 32'(bus.instr_req_o), 32'd0);
        arm_mode = 3; arm_target = 32'h104;
        run(2);
        check_eq("t6_flag_clr", 32'(bus.fetch_misaligned_o), 32'd0);
        run(6);
        check_eq("t6_resume_addr", qat(gnt_log, n0), 32'h104);
`else
        n0 = 0;
`endif

        // Randomized traffic with occasional mid-transaction resets
        gnt_wait_cfg = -1; lat_min = 0; lat_max = 2; ready_pct = 70; branch_pct = 6;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 350) do_rst = 1'b1;
            tick();
        end
        check_eq("rand_progress", 32'(dlv_log.size() > 200 + n0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
